// File: rtl/zap_copro_cp15.sv
// rtl/zap_copro_cp15.sv - CP15 system-control coprocessor executing MCR/MRC against a 16 x 32 register file
//
// Ports:
//   i_clk, i_reset            core clock, asynchronous active-high reset
//   i_copro_dav/i_copro_word  request valid (level) and instruction word from decode
//   o_copro_done              one-cycle completion pulse
//   o_reg_rd_en/_ndx          core register read strobe and index (MCR source)
//   i_reg_rd_data             core read data, valid one cycle after o_reg_rd_en
//   o_reg_wr_en/_ndx/_data    core register write strobe, index and data (MRC target)
//
// Build option: ZAP_COPRO_CYCCNT_EN turns c1 into a free-running, MCR-read-only cycle counter.
module zap_copro_cp15 #(
    parameter int          CP_NUM   = 15,
    parameter logic [31:0] CP_ID    = 32'h4100_0000,
    parameter int          PHY_REGS = 46
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_copro_dav,
    input  logic [31:0]                 i_copro_word,
    output logic                        o_copro_done,
    output logic                        o_reg_rd_en,
    output logic [$clog2(PHY_REGS)-1:0] o_reg_rd_ndx,
    input  logic [31:0]                 i_reg_rd_data,
    output logic                        o_reg_wr_en,
    output logic [$clog2(PHY_REGS)-1:0] o_reg_wr_ndx,
    output logic [31:0]                 o_reg_wr_data
);
    localparam int         NW     = $clog2(PHY_REGS);
    localparam logic [3:0] CP_SEL = 4'(CP_NUM);

    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_RD_REQ, S_RD_CAP, S_WR_CORE, S_DONE, S_WAIT_CLR
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_word;
    logic [31:0]   r_cregs [0:15];

    logic          w_l;
    logic [3:0]    w_crn;
    logic [3:0]    w_rd;
    logic          w_is_ours;
    logic          w_cp_wr_ok;
    logic          w_rd_en_nxt;
    logic          w_wr_en_nxt;
    logic          w_done_nxt;
    logic [NW-1:0] w_rd_ext;

    assign w_l       = r_word[20];
    assign w_crn     = r_word[19:16];
    assign w_rd      = r_word[15:12];
    assign w_rd_ext  = NW'(w_rd);
    assign w_is_ours = (r_word[27:24] == 4'b1110) && r_word[4] && (r_word[11:8] == CP_SEL);

    // c0 is the fixed ID; with the cycle counter built in, c1 belongs to the counter.
`ifdef ZAP_COPRO_CYCCNT_EN
    assign w_cp_wr_ok = (w_crn != 4'd0) && (w_crn != 4'd1);
`else
    assign w_cp_wr_ok = (w_crn != 4'd0);
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (i_copro_dav) w_state_nxt = S_DECODE;
            S_DECODE:   w_state_nxt = !w_is_ours ? S_DONE : (w_l ? S_WR_CORE : S_RD_REQ);
            S_RD_REQ:   w_state_nxt = S_RD_CAP;
            S_RD_CAP:   w_state_nxt = S_DONE;
            S_WR_CORE:  w_state_nxt = S_DONE;
            S_DONE:     w_state_nxt = S_WAIT_CLR;
            S_WAIT_CLR: if (!i_copro_dav) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
        // Decode flushed the request mid-flight: abandon without completing.
        if (!i_copro_dav && (r_state != S_IDLE) && (r_state != S_WAIT_CLR)) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Output logic: strobes are derived from the state being entered so they can be registered.
    always_comb begin
        w_rd_en_nxt = (w_state_nxt == S_RD_REQ);
        w_wr_en_nxt = (w_state_nxt == S_WR_CORE) && (w_rd != 4'd15);
        w_done_nxt  = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_word        <= '0;
            o_copro_done  <= 1'b0;
            o_reg_rd_en   <= 1'b0;
            o_reg_rd_ndx  <= '0;
            o_reg_wr_en   <= 1'b0;
            o_reg_wr_ndx  <= '0;
            o_reg_wr_data <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_copro_dav) begin
                r_word <= i_copro_word;
            end
            o_copro_done  <= w_done_nxt;
            o_reg_rd_en   <= w_rd_en_nxt;
            o_reg_rd_ndx  <= w_rd_en_nxt ? w_rd_ext : '0;
            o_reg_wr_en   <= w_wr_en_nxt;
            o_reg_wr_ndx  <= w_wr_en_nxt ? w_rd_ext : '0;
            o_reg_wr_data <= w_wr_en_nxt ? r_cregs[w_crn] : '0;
        end
    end

    // Coprocessor register file
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cregs[0] <= CP_ID;
            for (int i = 1; i < 16; i++) begin
                r_cregs[i] <= '0;
            end
        end else begin
`ifdef ZAP_COPRO_CYCCNT_EN
            r_cregs[1] <= r_cregs[1] + 32'd1;
`endif
            if ((r_state == S_RD_CAP) && w_cp_wr_ok) begin
                r_cregs[w_crn] <= i_reg_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_zap_copro_cp15.sv
// tb/tb_zap_copro_cp15.sv - randomized self-checking bench for zap_copro_cp15 against a field-level model
module tb_zap_copro_cp15;
    localparam logic [31:0] CP_ID = 32'h4100_0000;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_copro_dav = 1'b0;
    logic [31:0] i_copro_word = '0;
    logic        o_copro_done;
    logic        o_reg_rd_en;
    logic [5:0]  o_reg_rd_ndx;
    logic [31:0] i_reg_rd_data = '0;
    logic        o_reg_wr_en;
    logic [5:0]  o_reg_wr_ndx;
    logic [31:0] o_reg_wr_data;

    zap_copro_cp15 dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_copro_dav  (i_copro_dav),
        .i_copro_word (i_copro_word),
        .o_copro_done (o_copro_done),
        .o_reg_rd_en  (o_reg_rd_en),
        .o_reg_rd_ndx (o_reg_rd_ndx),
        .i_reg_rd_data(i_reg_rd_data),
        .o_reg_wr_en  (o_reg_wr_en),
        .o_reg_wr_ndx (o_reg_wr_ndx),
        .o_reg_wr_data(o_reg_wr_data)
    );

    always #5 i_clk = ~i_clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned tb_cyc = 0;

    logic [31:0] core  [0:15];
    logic [31:0] model [0:15];

    int          rd_cnt, wr_cnt, done_cnt, multi_cnt;
    int          rd_cyc, wr_cyc, done_cyc;
    logic [5:0]  rd_ndx_seen, wr_ndx_seen;
    logic [31:0] wr_data_seen;
    int unsigned wr_tb_cyc;

    always @(posedge i_clk) tb_cyc <= tb_cyc + 1;

    // Core register file read port: data one cycle after the strobe, garbage otherwise.
    always @(posedge i_clk)
        i_reg_rd_data <= o_reg_rd_en ? core[o_reg_rd_ndx[3:0]] : $urandom;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model[0] = CP_ID;
        for (int i = 1; i < 16; i++) model[i] = '0;
    endtask

    // Issue one request; dav drops hold+1 cycles after done, or at cycle drop_at (if nonzero).
    task automatic run_req(input logic [31:0] w, input int hold, input int drop_at);
        int s;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; multi_cnt = 0;
        rd_cyc = -1; wr_cyc = -1; done_cyc = -1;
        rd_ndx_seen = '0; wr_ndx_seen = '0; wr_data_seen = '0; wr_tb_cyc = 0;
        i_copro_word = w;
        i_copro_dav  = 1'b1;
        @(posedge i_clk); #1;
        for (int k = 1; k <= 14; k++) begin
            s = int'(o_reg_rd_en) + int'(o_reg_wr_en) + int'(o_copro_done);
            if (s > 1) multi_cnt++;
            if (o_reg_rd_en) begin
                rd_cnt++; rd_cyc = k; rd_ndx_seen = o_reg_rd_ndx;
            end
            if (o_reg_wr_en) begin
                wr_cnt++; wr_cyc = k; wr_ndx_seen = o_reg_wr_ndx;
                wr_data_seen = o_reg_wr_data; wr_tb_cyc = tb_cyc;
            end
            if (o_copro_done) begin
                done_cnt++; done_cyc = k;
            end
            if (drop_at != 0 && k == drop_at) i_copro_dav = 1'b0;
            if (done_cnt > 0 && k >= done_cyc + 1 + hold) i_copro_dav = 1'b0;
            @(posedge i_clk); #1;
        end
        i_copro_dav = 1'b0;
    endtask

    // Expected behaviour from the instruction fields; updates the model on MCR.
    task automatic check_req(input logic [31:0] w);
        logic       l, ours;
        logic [3:0] crn, rd;
        l    = w[20];
        crn  = w[19:16];
        rd   = w[15:12];
        ours = (w[27:24] == 4'hE) && w[4] && (w[11:8] == 4'hF);
        chk("multi_strobe", multi_cnt, 0);
        chk("done_cnt", done_cnt, 1);
        if (!ours) begin
            chk("ign_done_cyc", done_cyc, 2);
            chk("ign_rd_cnt", rd_cnt, 0);
            chk("ign_wr_cnt", wr_cnt, 0);
        end else if (!l) begin
            chk("mcr_rd_cnt", rd_cnt, 1);
            chk("mcr_rd_cyc", rd_cyc, 2);
            chk("mcr_rd_ndx", {26'd0, rd_ndx_seen}, {28'd0, rd});
            chk("mcr_wr_cnt", wr_cnt, 0);
            chk("mcr_done_cyc", done_cyc, 4);
`ifdef ZAP_COPRO_CYCCNT_EN
            if (crn != 4'd0 && crn != 4'd1) model[crn] = core[rd];
`else
            if (crn != 4'd0) model[crn] = core[rd];
`endif
        end else begin
            chk("mrc_rd_cnt", rd_cnt, 0);
            chk("mrc_done_cyc", done_cyc, 3);
            if (rd != 4'd15) begin
                chk("mrc_wr_cnt", wr_cnt, 1);
                chk("mrc_wr_cyc", wr_cyc, 2);
                chk("mrc_wr_ndx", {26'd0, wr_ndx_seen}, {28'd0, rd});
`ifdef ZAP_COPRO_CYCCNT_EN
                if (crn != 4'd1) chk("mrc_wr_data", wr_data_seen, model[crn]);
`else
                chk("mrc_wr_data", wr_data_seen, model[crn]);
`endif
            end else begin
                chk("mrc_r15_wr_cnt", wr_cnt, 0);
            end
        end
    endtask

    task automatic req(input logic [31:0] w, input int hold);
        run_req(w, hold, 0);
        check_req(w);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w, d0, d1;
        int unsigned c0;
        for (int i = 0; i < 16; i++) core[i] = $urandom;
        core[5] = 32'hDEAD_BEEF;
        core[2] = 32'h0;
        model_reset();

        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_done", o_copro_done, 0);
        chk("rst_rd_en", o_reg_rd_en, 0);
        chk("rst_wr_en", o_reg_wr_en, 0);
        chk("rst_wr_data", o_reg_wr_data, 0);
        i_reset = 1'b0;
        @(posedge i_clk); #1;

        // MCR c3<-r5, MRC c3->r7
        req(32'hEE03_5F10, 0);
        req(32'hEE13_7F10, 0);
        chk("mrc_c3_deadbeef", wr_data_seen, 32'hDEAD_BEEF);
        // c0 is read-only ID
        req(32'hEE10_2F10, 0);
        chk("mrc_c0_id", wr_data_seen, CP_ID);
        req(32'hEE00_2F10, 0);
        req(32'hEE10_2F10, 0);
        chk("mrc_c0_id_after_mcr", wr_data_seen, CP_ID);
        // foreign cp, CDP, MRC to r15, long dav hold
        req(32'hEE03_5E10, 0);
        req(32'hEE03_5F00, 0);
        req(32'hEE13_FF10, 0);
        req(32'hEE13_7F10, 5);
        chk("c3_unchanged", wr_data_seen, 32'hDEAD_BEEF);

        // Flush in RD_REQ: no done, no CP write, block returns to IDLE
        core[1] = 32'h1234_5678;
        req(32'hEE06_1F10, 0);
        core[2] = 32'hA5A5_A5A5;
        run_req(32'hEE06_2F10, 0, 2);
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_rd_cyc", rd_cyc, 2);
        chk("abort_wr_cnt", wr_cnt, 0);
        req(32'hEE16_3F10, 0);
        chk("abort_c6_kept", wr_data_seen, 32'h1234_5678);

        // Async reset while in RD_CAP
        core[9] = 32'hCAFE_F00D;
        i_copro_word = 32'hEE03_9F10;
        i_copro_dav  = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        #1;
        chk("arst_done", o_copro_done, 0);
        chk("arst_rd_en", o_reg_rd_en, 0);
        chk("arst_rd_ndx", {26'd0, o_reg_rd_ndx}, 0);
        chk("arst_wr_en", o_reg_wr_en, 0);
        i_copro_dav = 1'b0;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        model_reset();
        @(posedge i_clk); #1;
        req(32'hEE13_7F10, 0);
        chk("arst_c3_zero", wr_data_seen, 0);

`ifdef ZAP_COPRO_CYCCNT_EN
        req(32'hEE11_4F10, 0);
        d0 = wr_data_seen;
        c0 = wr_tb_cyc;
        repeat ($urandom_range(1, 20)) @(posedge i_clk);
        #1;
        req(32'hEE11_4F10, 0);
        d1 = wr_data_seen;
        chk("cyccnt_delta", d1 - d0, wr_tb_cyc - c0);
        core[4] = 32'h0000_0000;
        req(32'hEE01_4F10, 0);
        req(32'hEE11_4F10, 0);
        chk("cyccnt_ro", (wr_data_seen - d1) > 32'd3 ? 32'd1 : 32'd0, 32'd1);
`endif

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) core[$urandom_range(0, 15)] = $urandom;
            w = $urandom;
            if ($urandom_range(0, 9) < 8) w[27:24] = 4'hE;
            if ($urandom_range(0, 9) < 8) w[4] = 1'b1;
            if ($urandom_range(0, 9) < 8) w[11:8] = 4'hF;
            req(w, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
